// File: rtl/cic_pkg.sv
// cic_pkg: shared widths, width-table lookup and truncation helpers for the pruned CIC decimator.
package cic_pkg;
  localparam int MAX_B = 128;
  localparam int MAX_ST = 32;
  typedef enum logic {MODE_INT, MODE_COMB} stage_mode_e;
  function automatic int b_full(input int i_w, input int order, input int dec_bits);
    return i_w + order * dec_bits;
  endfunction
  function automatic int width_of(input logic [8*MAX_ST-1:0] widths, input int k);
    return int'(widths[8*k +: 8]);
  endfunction
  // Keep the top bits of a wider stage: floor toward -inf, no rounding.
  function automatic logic signed [MAX_B-1:0] trunc(input logic signed [MAX_B-1:0] x, input int sh);
    return x >>> sh;
  endfunction
endpackage

// File: rtl/cic_stage.sv
// cic_stage: one pruned integrator or M=1 comb; values travel sign-extended on a B_W-bit bus.
module cic_stage
  import cic_pkg::*;
#(
  parameter int B_W = 64,
  parameter int IN_W = 64,
  parameter int OUT_W = 64,
  parameter stage_mode_e MODE = MODE_INT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic signed [B_W-1:0] i_x,
  output logic signed [B_W-1:0] o_y
);
  logic signed [OUT_W-1:0] w_x, w_y, r_acc;
  assign w_x = OUT_W'(trunc(MAX_B'(i_x), IN_W - OUT_W));
  assign w_y = (MODE == MODE_INT) ? r_acc : w_x - r_acc;
  assign o_y = B_W'(w_y);
  always_ff @(posedge i_clk)
    if (!i_rst) r_acc <= '0;
    else if (i_en) r_acc <= (MODE == MODE_INT) ? r_acc + w_x : w_x;
endmodule

// File: rtl/cic_pruned_decimator.sv
// cic_pruned_decimator: power-of-two CIC decimator with Hogenauer-pruned stage widths and a decimated clock.
module cic_pruned_decimator
  import cic_pkg::*;
#(
  parameter int I_WIDTH = 16,
  parameter int ORDER = 3,
  parameter int DECIMATION_BITS = 16,
  parameter logic [8*(2*ORDER+1)-1:0] REG_WIDTHS = {8'd16, 8'd18, 8'd19, 8'd20, 8'd27, 8'd42, 8'd57},
  parameter int O_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic signed [I_WIDTH-1:0] i_data,
  output logic signed [O_WIDTH-1:0] o_data,
  output logic                      o_clk
);
  localparam int LP_B = b_full(I_WIDTH, ORDER, DECIMATION_BITS);
  localparam logic [8*MAX_ST-1:0] LP_W = {{(8*(MAX_ST-2*ORDER-1)){1'b0}}, REG_WIDTHS};
  localparam int LP_LAST = width_of(LP_W, 2*ORDER-1);
  logic [DECIMATION_BITS-1:0] r_cnt;
  logic signed [O_WIDTH-1:0] r_data;
  logic signed [LP_B-1:0] w_chain [0:2*ORDER];
  logic w_tick;
  assign w_tick = i_en & (&r_cnt);
  assign w_chain[0] = LP_B'(i_data);
  assign o_data = r_data;
  assign o_clk = r_cnt[DECIMATION_BITS-1];
  // Integrators run every enabled cycle; combs see integrator N's pre-edge value on ticks.
  for (genvar k = 0; k < 2*ORDER; k++) begin : g_stage
    localparam int LP_IN = (k == 0) ? LP_B : width_of(LP_W, (k == 0) ? 0 : k - 1);
    localparam int LP_OUT = width_of(LP_W, k);
    localparam stage_mode_e LP_MODE = stage_mode_e'(k >= ORDER);
    cic_stage #(.B_W(LP_B), .IN_W(LP_IN), .OUT_W(LP_OUT), .MODE(LP_MODE)) u_stage (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_en (k < ORDER ? i_en : w_tick),
      .i_x  (w_chain[k]),
      .o_y  (w_chain[k+1])
    );
  end
  always_ff @(posedge i_clk)
    if (!i_rst) begin
      r_cnt <= '0;
      r_data <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_tick) r_data <= O_WIDTH'(trunc(MAX_B'(w_chain[2*ORDER]), LP_LAST - O_WIDTH));
    end
endmodule

// File: tb/tb_cic_pruned_decimator.sv
// tb_cic_pruned_decimator: directed checks on a pruned R=16 filter and two exact-width R=16 filters.
module tb_cic_pruned_decimator;
  localparam logic [55:0] PRUNED = {8'd16, 8'd18, 8'd19, 8'd20, 8'd26, 8'd27, 8'd28};
  localparam logic [55:0] EXACT = {8'd16, {6{8'd28}}};
  logic clk = 1'b0;
  logic p_rst, x_rst, b_en;
  logic signed [15:0] p_data, a_data, b_data, p_out, a_out, b_out;
  logic p_clk, a_clk, b_clk;
  int checks = 0;
  int failures = 0;
  int cold [1:8];
  int imp [0:8] = '{91, 162, 3, 0, 0, 0, 0, 0, 0};
  int qa [$];
  int qb [$];
  int nb, k, sum, nz;

  always #5 clk = ~clk;

  cic_pruned_decimator #(.I_WIDTH(16), .ORDER(3), .DECIMATION_BITS(4), .REG_WIDTHS(PRUNED), .O_WIDTH(16)) u_p (
    .i_clk(clk), .i_rst(p_rst), .i_en(1'b1), .i_data(p_data), .o_data(p_out), .o_clk(p_clk));
  cic_pruned_decimator #(.I_WIDTH(16), .ORDER(3), .DECIMATION_BITS(4), .REG_WIDTHS(EXACT), .O_WIDTH(16)) u_a (
    .i_clk(clk), .i_rst(x_rst), .i_en(1'b1), .i_data(a_data), .o_data(a_out), .o_clk(a_clk));
  cic_pruned_decimator #(.I_WIDTH(16), .ORDER(3), .DECIMATION_BITS(4), .REG_WIDTHS(EXACT), .O_WIDTH(16)) u_b (
    .i_clk(clk), .i_rst(x_rst), .i_en(b_en), .i_data(b_data), .o_data(b_out), .o_clk(b_clk));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  initial begin
    p_rst = 1'b0; x_rst = 1'b0; b_en = 1'b1;
    p_data = '0; a_data = '0; b_data = '0;
    for (int i = 0; i < 3; i++) begin
      p_data = 16'($urandom);
      cyc();
    end
    check("rst_data", p_out, 0);
    check("rst_clk", p_clk, 0);
    p_data = '0;
    p_rst = 1'b1;
    k = 0;
    while (p_clk !== 1'b1 && k < 100) begin cyc(); k++; end
    check("clk_rise", k, 8);
    while (p_clk !== 1'b0 && k < 100) begin cyc(); k++; end
    check("clk_fall", k, 16);
    for (int i = 0; i < 160; i++) begin
      cyc();
      check("zero_data", p_out, 0);
    end
    p_rst = 1'b0;
    cyc();
    p_data = 16'sh4000;
    p_rst = 1'b1;
    for (int m = 1; m <= 8; m++) begin
      repeat (16) cyc();
      cold[m] = p_out;
      if (m >= 4) check_range("step_pos", p_out, 16381, 16384);
    end
    p_rst = 1'b0;
    cyc();
    p_data = -16'sd16384;
    p_rst = 1'b1;
    for (int m = 1; m <= 8; m++) begin
      repeat (16) cyc();
      if (m >= 4) check_range("step_neg", p_out, -16387, -16384);
    end
    p_rst = 1'b0;
    cyc();
    p_data = 16'sh4000;
    p_rst = 1'b1;
    repeat (40) cyc();
    p_rst = 1'b0;
    cyc();
    check("midrst_data", p_out, 0);
    check("midrst_clk", p_clk, 0);
    p_rst = 1'b1;
    for (int m = 1; m <= 8; m++) begin
      repeat (16) cyc();
      check("restart", p_out, cold[m]);
    end
    x_rst = 1'b0;
    cyc();
    x_rst = 1'b1;
    nb = 0;
    a_data = 16'sh1000;
    b_data = 16'sh1000;
    for (int c = 1; c <= 340; c++) begin
      b_en = !(c >= 21 && c <= 57);
      cyc();
      if (b_en) nb++;
      a_data = (c >= 150) ? 16'sd1 : 16'sd0;
      b_data = (nb >= 150) ? 16'sd1 : 16'sd0;
      if (c % 16 == 0) qa.push_back(int'(a_out));
      if (b_en && nb % 16 == 0) qb.push_back(int'(b_out));
      if (!b_en) begin
        check("gap_clk", b_clk, 0);
        check("gap_data", b_out, 91);
      end
    end
    check("qb_len", qb.size(), 18);
    sum = 0; nz = 0;
    for (int m = 0; m <= 8; m++) begin
      check("imp_a", qa[m], imp[m]);
      if (m < qb.size()) check("imp_b", qb[m], imp[m]);
      sum += qa[m];
      if (qa[m] != 0) nz++;
    end
    check("imp_sum", sum, 256);
    check("imp_nz", nz, 3);
    for (int m = 9; m < 18 && m < qb.size(); m++) check("gap_shift", qb[m], qa[m]);
    check("step1_a", qa[20], 1);
    if (qb.size() >= 18) check("step1_b", qb[17], 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
